// File: rtl/mono_vidport.sv
// Monochrome video output stage: MDA pixel/sync in, palette-mapped VGA DAC codes out.
// Optional MONO_DIM_EN macro renders intensity-without-video at the dim level.
module mono_vidport #(
  parameter int RW       = 6,
  parameter int GW       = 7,
  parameter int BW       = 6,
  parameter int PIPE     = 2,
  parameter int H_BACK   = 9,
  parameter int H_ACTIVE = 720,
  parameter int V_BACK   = 4,
  parameter int V_ACTIVE = 350,
  parameter bit HS_INV   = 1'b0,
  parameter bit VS_INV   = 1'b1
) (
  input  logic          clk,
  input  logic          busreset,
  input  logic          video,
  input  logic          intensity,
  input  logic          hsync,
  input  logic          vsync,
  input  logic          mode_wr,
  input  logic [1:0]    mode_in,
  input  logic [2:0]    cust_en,
  output logic [RW-1:0] red,
  output logic [GW-1:0] green,
  output logic [BW-1:0] blue,
  output logic          vga_hsync,
  output logic          vga_vsync,
  output logic          frame_start
);

  typedef enum logic [1:0] {PAL_GREEN, PAL_AMBER, PAL_WHITE, PAL_CUSTOM} pal_t;
  typedef enum logic {IDLE, PENDING} state_t;

  localparam logic [15:0] R_FULL = 16'((1 << RW) - 1);
  localparam logic [15:0] G_FULL = 16'((1 << GW) - 1);
  localparam logic [15:0] B_FULL = 16'((1 << BW) - 1);

  function automatic logic [15:0] level_of(input logic [1:0] vi, input logic [15:0] full);
    case (vi)
      2'b11:   level_of = full;
      2'b10:   level_of = full - (full >> 2);
`ifdef MONO_DIM_EN
      2'b01:   level_of = full >> 2;
`endif
      default: level_of = '0;
    endcase
  endfunction

  logic [3:0] in_bus;
  logic [3:0] s_p0;
  assign in_bus = {video, intensity, hsync, vsync};

  // Stage p0: PIPE plain delay registers
  generate
    if (PIPE == 0) begin : g_nopipe
      assign s_p0 = in_bus;
    end else begin : g_pipe
      logic [3:0] stg [PIPE];
      always_ff @(posedge clk) begin
        if (busreset) begin
          for (int i = 0; i < PIPE; i++) stg[i] <= '0;
        end else begin
          stg[0] <= in_bus;
          for (int i = 1; i < PIPE; i++) stg[i] <= stg[i-1];
        end
      end
      assign s_p0 = stg[PIPE-1];
    end
  endgenerate

  // Stage p1: edge detect; sync edges line up with the pixel that carries them
  logic vid_p1, int_p1, hs_p1, vs_p1, hs_rise_p1, vs_rise_p1;
  always_ff @(posedge clk) begin
    if (busreset) begin
      vid_p1 <= 1'b0; int_p1 <= 1'b0; hs_p1 <= 1'b0; vs_p1 <= 1'b0;
      hs_rise_p1 <= 1'b0; vs_rise_p1 <= 1'b0;
    end else begin
      vid_p1     <= s_p0[3];
      int_p1     <= s_p0[2];
      hs_p1      <= s_p0[1];
      vs_p1      <= s_p0[0];
      hs_rise_p1 <= s_p0[1] & ~hs_p1;
      vs_rise_p1 <= s_p0[0] & ~vs_p1;
    end
  end

  logic [10:0] hcount;
  logic [9:0]  vcount;
  always_ff @(posedge clk) begin
    if (busreset) begin
      hcount <= 11'd2047;
      vcount <= 10'd1023;
    end else begin
      if (hs_rise_p1)              hcount <= '0;
      else if (hcount != 11'd2047) hcount <= hcount + 11'd1;
      if (vs_rise_p1)                           vcount <= '0;
      else if (hs_rise_p1 && vcount != 10'd1023) vcount <= vcount + 10'd1;
    end
  end

  pal_t       palette, pending;
  state_t     state;
  logic [2:0] cust;
  // A write coinciding with the vsync edge bypasses the pending register
  always_ff @(posedge clk) begin
    if (busreset) begin
      palette <= PAL_GREEN;
      pending <= PAL_GREEN;
      state   <= IDLE;
      cust    <= '0;
    end else if (mode_wr && vs_rise_p1) begin
      palette <= pal_t'(mode_in);
      cust    <= cust_en;
      state   <= IDLE;
    end else if (mode_wr) begin
      pending <= pal_t'(mode_in);
      state   <= PENDING;
    end else if (state == PENDING && vs_rise_p1) begin
      palette <= pending;
      cust    <= cust_en;
      state   <= IDLE;
    end
  end

  logic        active;
  logic [15:0] r_lvl, g_lvl, b_lvl, r_c, g_c, b_c;
  always_comb begin
    active = (int'(hcount) >= H_BACK) && (int'(hcount) < H_BACK + H_ACTIVE) &&
             (int'(vcount) >= V_BACK) && (int'(vcount) < V_BACK + V_ACTIVE);
    r_lvl = level_of({vid_p1, int_p1}, R_FULL);
    g_lvl = level_of({vid_p1, int_p1}, G_FULL);
    b_lvl = level_of({vid_p1, int_p1}, B_FULL);
    r_c = '0;
    g_c = '0;
    b_c = '0;
    case (palette)
      PAL_GREEN:  g_c = g_lvl;
      PAL_AMBER:  begin r_c = r_lvl; g_c = g_lvl >> 1; end
      PAL_WHITE:  begin r_c = r_lvl; g_c = g_lvl; b_c = b_lvl; end
      PAL_CUSTOM: begin
        r_c = cust[2] ? r_lvl : '0;
        g_c = cust[1] ? g_lvl : '0;
        b_c = cust[0] ? b_lvl : '0;
      end
      default: ;
    endcase
  end

  // Stage p2: registered pins
  always_ff @(posedge clk) begin
    if (busreset) begin
      red         <= '0;
      green       <= '0;
      blue        <= '0;
      vga_hsync   <= HS_INV;
      vga_vsync   <= VS_INV;
      frame_start <= 1'b0;
    end else begin
      red         <= active ? r_c[RW-1:0] : '0;
      green       <= active ? g_c[GW-1:0] : '0;
      blue        <= active ? b_c[BW-1:0] : '0;
      vga_hsync   <= hs_p1 ^ HS_INV;
      vga_vsync   <= vs_p1 ^ VS_INV;
      frame_start <= vs_rise_p1;
    end
  end

endmodule

// File: tb/tb_mono_vidport.sv
// Directed self-checking bench for mono_vidport with default parameters.
module tb_mono_vidport;

  logic       clk = 1'b0;
  logic       busreset, video, intensity, hsync, vsync, mode_wr;
  logic [1:0] mode_in;
  logic [2:0] cust_en;
  logic [5:0] red;
  logic [6:0] green;
  logic [5:0] blue;
  logic       vga_hsync, vga_vsync, frame_start;

  int checks = 0;
  int passes = 0;
  int vline  = 0;

  mono_vidport dut (
    .clk(clk), .busreset(busreset), .video(video), .intensity(intensity),
    .hsync(hsync), .vsync(vsync), .mode_wr(mode_wr), .mode_in(mode_in),
    .cust_en(cust_en), .red(red), .green(green), .blue(blue),
    .vga_hsync(vga_hsync), .vga_vsync(vga_vsync), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic v, input logic i, input logic h, input logic vs);
    video = v; intensity = i; hsync = h; vsync = vs;
    @(posedge clk); #1;
  endtask

  task automatic hpulse();
    drive(0, 0, 1, 0);
    drive(0, 0, 0, 0);
    vline++;
  endtask

  task automatic start_frame();
    drive(0, 0, 0, 1);
    drive(0, 0, 0, 0);
    vline = 0;
    repeat (3) hpulse();
  endtask

  task automatic write_mode(input logic [1:0] m);
    mode_wr = 1'b1; mode_in = m;
    drive(0, 0, 0, 0);
    mode_wr = 1'b0;
  endtask

  // New line, pixel at hcount h, then wait for it to reach the pins
  task automatic pix_at(input int h, input logic v, input logic i,
                        output logic [18:0] rgb);
    drive(0, 0, 1, 0);
    vline++;
    repeat (h) drive(0, 0, 0, 0);
    drive(v, i, 0, 0);
    repeat (3) drive(0, 0, 0, 0);
    rgb = {red, green, blue};
  endtask

  task automatic test_reset();
    busreset = 1'b1; mode_wr = 1'b0; mode_in = 2'd0; cust_en = 3'b000;
    repeat (3) drive(1, 1, 0, 0);
    checks++;
    if ({red, green, blue} !== 19'd0) $display("FAIL reset_rgb: got %h want 0", {red, green, blue});
    else passes++;
    checks++;
    if ({vga_hsync, vga_vsync, frame_start} !== 3'b010)
      $display("FAIL reset_sync: got %b want 010", {vga_hsync, vga_vsync, frame_start});
    else passes++;
    checks++;
    if ({dut.hcount, dut.vcount} !== {11'd2047, 10'd1023})
      $display("FAIL reset_counters: got %0d/%0d want 2047/1023", dut.hcount, dut.vcount);
    else passes++;
    busreset = 1'b0;
    drive(0, 0, 0, 0);
  endtask

  task automatic test_green_latency();
    start_frame();
    drive(0, 0, 1, 0);
    vline++;
    repeat (20) drive(0, 0, 0, 0);
    drive(1, 1, 0, 0);
    repeat (2) drive(0, 0, 0, 0);
    checks++;
    if (green !== 7'd0) $display("FAIL latency_early: got %0d want 0", green);
    else passes++;
    drive(0, 0, 0, 0);
    checks++;
    if ({red, green, blue} !== {6'd0, 7'd127, 6'd0})
      $display("FAIL green_full: got %0d/%0d/%0d want 0/127/0", red, green, blue);
    else passes++;
  endtask

  task automatic test_window();
    logic [18:0] rgb;
    write_mode(2'd2);
    start_frame();
    pix_at(8, 1, 1, rgb);
    checks++;
    if (rgb !== 19'd0) $display("FAIL win_h_before: got %h want 0", rgb);
    else passes++;
    pix_at(9, 1, 1, rgb);
    checks++;
    if (rgb !== {6'd63, 7'd127, 6'd63}) $display("FAIL win_h_first: got %h want %h", rgb, {6'd63, 7'd127, 6'd63});
    else passes++;
    pix_at(728, 1, 1, rgb);
    checks++;
    if (rgb !== {6'd63, 7'd127, 6'd63}) $display("FAIL win_h_last: got %h want %h", rgb, {6'd63, 7'd127, 6'd63});
    else passes++;
    pix_at(729, 1, 1, rgb);
    checks++;
    if (rgb !== 19'd0) $display("FAIL win_h_after: got %h want 0", rgb);
    else passes++;
    while (vline < 352) hpulse();
    pix_at(20, 1, 1, rgb);
    checks++;
    if (rgb !== {6'd63, 7'd127, 6'd63}) $display("FAIL win_v_last: got %h want %h", rgb, {6'd63, 7'd127, 6'd63});
    else passes++;
    pix_at(20, 1, 1, rgb);
    checks++;
    if (rgb !== 19'd0) $display("FAIL win_v_after: got %h want 0", rgb);
    else passes++;
  endtask

  task automatic test_mode_switch();
    logic [18:0] rgb;
    int fs_count;
    start_frame();
    pix_at(20, 1, 0, rgb);
    checks++;
    if (rgb !== {6'd48, 7'd96, 6'd48}) $display("FAIL white_norm: got %h want %h", rgb, {6'd48, 7'd96, 6'd48});
    else passes++;
    write_mode(2'd1);
    pix_at(20, 1, 0, rgb);
    checks++;
    if (rgb !== {6'd48, 7'd96, 6'd48}) $display("FAIL mid_frame_hold: got %h want %h", rgb, {6'd48, 7'd96, 6'd48});
    else passes++;
    fs_count = 0;
    drive(0, 0, 0, 1);
    fs_count += int'(frame_start);
    repeat (7) begin
      drive(0, 0, 0, 0);
      fs_count += int'(frame_start);
    end
    checks++;
    if (fs_count != 1) $display("FAIL frame_start_pulses: got %0d want 1", fs_count);
    else passes++;
    vline = 0;
    repeat (3) hpulse();
    pix_at(20, 1, 0, rgb);
    checks++;
    if (rgb !== {6'd48, 7'd48, 6'd0}) $display("FAIL amber_norm: got %h want %h", rgb, {6'd48, 7'd48, 6'd0});
    else passes++;
  endtask

  task automatic test_back_to_back();
    logic [18:0] rgb;
    write_mode(2'd2);
    pix_at(20, 1, 1, rgb);
    checks++;
    if (rgb !== {6'd63, 7'd63, 6'd0}) $display("FAIL pending_not_shown: got %h want %h", rgb, {6'd63, 7'd63, 6'd0});
    else passes++;
    cust_en = 3'b101;
    write_mode(2'd3);
    start_frame();
    pix_at(20, 1, 1, rgb);
    checks++;
    if (rgb !== {6'd63, 7'd0, 6'd63}) $display("FAIL custom_101: got %h want %h", rgb, {6'd63, 7'd0, 6'd63});
    else passes++;
  endtask

  // Write lands in the same cycle as the internal vsync edge (3 clocks after input)
  task automatic test_same_cycle();
    logic [18:0] rgb;
    drive(0, 0, 0, 1);
    drive(0, 0, 0, 0);
    drive(0, 0, 0, 0);
    write_mode(2'd0);
    vline = 0;
    repeat (3) hpulse();
    pix_at(20, 1, 1, rgb);
    checks++;
    if (rgb !== {6'd0, 7'd127, 6'd0}) $display("FAIL same_cycle_apply: got %h want %h", rgb, {6'd0, 7'd127, 6'd0});
    else passes++;
  endtask

  task automatic test_dim();
    logic [18:0] rgb;
    logic [18:0] want;
`ifdef MONO_DIM_EN
    want = {6'd0, 7'd31, 6'd0};
`else
    want = 19'd0;
`endif
    pix_at(20, 0, 1, rgb);
    checks++;
    if (rgb !== want) $display("FAIL dim_level: got %h want %h", rgb, want);
    else passes++;
  endtask

  task automatic test_sync_polarity();
    repeat (5) drive(0, 0, 0, 1);
    checks++;
    if (vga_vsync !== 1'b0) $display("FAIL vsync_active: got %b want 0", vga_vsync);
    else passes++;
    repeat (5) drive(0, 0, 0, 0);
    checks++;
    if (vga_vsync !== 1'b1) $display("FAIL vsync_idle: got %b want 1", vga_vsync);
    else passes++;
    repeat (5) drive(0, 0, 1, 0);
    checks++;
    if (vga_hsync !== 1'b1) $display("FAIL hsync_active: got %b want 1", vga_hsync);
    else passes++;
    repeat (5) drive(0, 0, 0, 0);
    checks++;
    if (vga_hsync !== 1'b0) $display("FAIL hsync_idle: got %b want 0", vga_hsync);
    else passes++;
  endtask

  task automatic test_starvation();
    start_frame();
    drive(0, 0, 1, 0);
    repeat (3000) drive(1, 1, 0, 0);
    checks++;
    if (dut.hcount !== 11'd2047) $display("FAIL hcount_saturate: got %0d want 2047", dut.hcount);
    else passes++;
    checks++;
    if ({red, green, blue} !== 19'd0) $display("FAIL starved_blank: got %h want 0", {red, green, blue});
    else passes++;
  endtask

  task automatic test_reset_pending();
    logic [18:0] rgb;
    write_mode(2'd2);
    busreset = 1'b1;
    drive(0, 0, 0, 0);
    busreset = 1'b0;
    start_frame();
    pix_at(20, 1, 1, rgb);
    checks++;
    if (rgb !== {6'd0, 7'd127, 6'd0}) $display("FAIL reset_discards_pending: got %h want %h", rgb, {6'd0, 7'd127, 6'd0});
    else passes++;
  endtask

  initial begin
    busreset = 1'b1; video = 0; intensity = 0; hsync = 0; vsync = 0;
    mode_wr = 0; mode_in = 0; cust_en = 0;
    test_reset();
    test_green_latency();
    test_window();
    test_mode_switch();
    test_back_to_back();
    test_same_cycle();
    test_dim();
    test_sync_polarity();
    test_starvation();
    test_reset_pending();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
